tt_ctrl_seq: RTL and testbench

// - Drives the chip's 3-pin design-select interface (ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena) from the board/management side.
// - Takes an address request and resets the selection counter, pulses inc A times, then optionally raises ena.
// - Sits on the test-board controller; outputs go to the chip's control-high pads.

---
 rtl/tt_ctrl_seq.sv | 186 ++++++++++++++++++
 tb/tb_tt_ctrl_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_ctrl_seq.sv
// Sequencer for the chip's 3-pin design-select interface: reset counter, pulse inc A times, optionally enable.
// Optional TT_CTRL_SEQ_INCR_EN: when the current selection is valid and A >= cur_addr, only pulse the difference.
module tt_ctrl_seq #(
  parameter int ADDR_W = 10,
  parameter int PH_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  typedef enum logic [2:0] {
    IDLE, DIS, RST_LO, RST_HI, INC_HI, INC_LO, FIN
  } state_t;

  localparam logic [7:0] PH_LD = 8'(PH_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        tmr_q, tmr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ena_q, ena_d;
  logic              skip_q, skip_d;

  logic              rdy_d, done_d, busy_d, cur_valid_d;
  logic              rst_n_d, inc_d, cena_d;
  logic [ADDR_W-1:0] cur_addr_d;
  logic              ph_end;

  assign ph_end = (tmr_q == 8'd0);

  // Pin levels are computed for the state being entered, so each pin
  // changes on the same edge as the state transition.
  always_comb begin
    state_d     = state_q;
    tmr_d       = ph_end ? tmr_q : tmr_q - 8'd1;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    ena_d       = ena_q;
    skip_d      = skip_q;
    done_d      = 1'b0;
    busy_d      = busy;
    cur_addr_d  = cur_addr;
    cur_valid_d = cur_valid;
    rst_n_d     = ctrl_sel_rst_n;
    inc_d       = ctrl_sel_inc;
    cena_d      = ctrl_ena;

    case (state_q)
      IDLE: begin
        // Only a fresh reset leaves rst_n low here; release it on the first clock.
        rst_n_d = 1'b1;
        busy_d  = 1'b0;
        if (req_valid && req_ready) begin
          state_d     = DIS;
          tmr_d       = PH_LD;
          addr_d      = req_addr;
          ena_d       = req_ena;
          busy_d      = 1'b1;
          cena_d      = 1'b0;
          cur_valid_d = 1'b0;
`ifdef TT_CTRL_SEQ_INCR_EN
          if (cur_valid && (req_addr >= cur_addr)) begin
            skip_d = 1'b1;
            cnt_d  = req_addr - cur_addr;
          end else begin
            skip_d = 1'b0;
            cnt_d  = req_addr;
          end
`else
          skip_d = 1'b0;
          cnt_d  = req_addr;
`endif
        end
      end
      DIS: begin
        if (ph_end) begin
          tmr_d = PH_LD;
          if (!skip_q) begin
            state_d = RST_LO;
            rst_n_d = 1'b0;
          end else if (cnt_q == '0) begin
            state_d = FIN;
          end else begin
            state_d = INC_HI;
            inc_d   = 1'b1;
          end
        end
      end
      RST_LO: begin
        if (ph_end) begin
          state_d = RST_HI;
          tmr_d   = PH_LD;
          rst_n_d = 1'b1;
        end
      end
      RST_HI: begin
        if (ph_end) begin
          tmr_d = PH_LD;
          if (cnt_q == '0) begin
            state_d = FIN;
          end else begin
            state_d = INC_HI;
            inc_d   = 1'b1;
          end
        end
      end
      INC_HI: begin
        if (ph_end) begin
          state_d = INC_LO;
          tmr_d   = PH_LD;
          inc_d   = 1'b0;
        end
      end
      INC_LO: begin
        if (ph_end) begin
          tmr_d = PH_LD;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q != ADDR_W'(1)) begin
            state_d = INC_HI;
            inc_d   = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d     = IDLE;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        cena_d      = ena_q;
        cur_addr_d  = addr_q;
        cur_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Hold off ready for the done cycle so done and ready never overlap.
    rdy_d = (state_d == IDLE) && !done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      tmr_q          <= 8'd0;
      cnt_q          <= '0;
      addr_q         <= '0;
      ena_q          <= 1'b0;
      skip_q         <= 1'b0;
      req_ready      <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
      cur_addr       <= '0;
      cur_valid      <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      ena_q          <= ena_d;
      skip_q         <= skip_d;
      req_ready      <= rdy_d;
      done           <= done_d;
      busy           <= busy_d;
      cur_addr       <= cur_addr_d;
      cur_valid      <= cur_valid_d;
      ctrl_sel_rst_n <= rst_n_d;
      ctrl_sel_inc   <= inc_d;
      ctrl_ena       <= cena_d;
    end
  end

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Bench for tt_ctrl_seq: directed table, multi-cycle corner sequences and randomized requests vs. a timing model.
module tb_tt_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rv [2];
  logic [9:0] ra [2];
  logic       re [2];
  wire        rr [2];
  wire        dn [2];
  wire        bz [2];
  wire [9:0]  ca [2];
  wire        cv [2];
  wire        rn [2];
  wire        ic [2];
  wire        en [2];

  always #5 clk = ~clk;

  // Unit 0: PH_CYC=2 for most tests; unit 1: PH_CYC=1 for the full-range address.
  tt_ctrl_seq #(.ADDR_W(10), .PH_CYC(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .req_addr(ra[0]),
    .req_ena(re[0]), .done(dn[0]), .busy(bz[0]), .cur_addr(ca[0]), .cur_valid(cv[0]),
    .ctrl_sel_rst_n(rn[0]), .ctrl_sel_inc(ic[0]), .ctrl_ena(en[0]));
  tt_ctrl_seq #(.ADDR_W(10), .PH_CYC(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .req_addr(ra[1]),
    .req_ena(re[1]), .done(dn[1]), .busy(bz[1]), .cur_addr(ca[1]), .cur_valid(cv[1]),
    .ctrl_sel_rst_n(rn[1]), .ctrl_sel_inc(ic[1]), .ctrl_ena(en[1]));

  int n_vec = 0;
  int n_err = 0;
  bit mv [2];
  int ma [2];

  typedef struct {
    int a;
    bit e;
    int lat;
    int pul;
    int rlo;
  } vec_t;
  vec_t tbl [4];

  function automatic void chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int ph(int s);
    return (s == 0) ? 2 : 1;
  endfunction

  // Expected timing from the request and the remembered selection.
  task automatic model(input int s, input int a, output int lat, output int pul,
                       output int rlo, output int ifirst);
    bit full;
    int n;
    full = 1'b1;
    n    = a;
`ifdef TT_CTRL_SEQ_INCR_EN
    if (mv[s] && a >= ma[s]) begin
      full = 1'b0;
      n    = a - ma[s];
    end
`endif
    lat    = ((full ? 3 : 1) + 2 * n) * ph(s) + 1;
    pul    = n;
    rlo    = full ? ph(s) : 0;
    ifirst = (full ? 3 : 1) * ph(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rv[0] = 1'b0; rv[1] = 1'b0;
    @(negedge clk);
    chk("rst rst_n", rn[0], 0);
    chk("rst inc", ic[0], 0);
    chk("rst ena", en[0], 0);
    chk("rst done", dn[0], 0);
    chk("rst busy", bz[0], 0);
    chk("rst cur_valid", cv[0], 0);
    chk("rst cur_addr", ca[0], 0);
    rst = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0;
    @(negedge clk);
    chk("rel rst_n", rn[0], 1);
    chk("rel ready", rr[0], 1);
  endtask

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic run_req(input int s, input int a, input bit e, input bit hold, input int ha,
                         input bit he, input int x_lat, input int x_pul, input int x_rlo,
                         input int x_ifirst, input string tag);
    int k, cyc, pul, rlo, rfirst, ifirst, hrun, lrun, viol, werr;
    bit pinc, seen;
    rv[s] = 1'b1; ra[s] = 10'(a); re[s] = e;
    cyc = 0;
    while (!rr[s] && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!rr[s]) begin
      chk({tag, " accept"}, 0, 1);
      rv[s] = 1'b0;
      return;
    end
    @(negedge clk);
    if (hold) begin
      ra[s] = 10'(ha); re[s] = he;
    end else begin
      rv[s] = 1'b0;
    end
    k = 0; pul = 0; rlo = 0; rfirst = -1; ifirst = -1;
    hrun = 0; lrun = 0; viol = 0; werr = 0; pinc = 1'b0; seen = 1'b0;
    while (k < 5000) begin
      if (dn[s]) begin
        seen = 1'b1;
        if (rr[s] || ic[s] || !rn[s]) viol++;
        break;
      end
      if (!bz[s] || rr[s] || en[s] || cv[s] || (ic[s] && !rn[s])) viol++;
      if (!rn[s]) begin
        rlo++;
        if (rfirst < 0) rfirst = k;
      end
      if (ic[s]) begin
        if (!pinc) begin
          pul++;
          if (ifirst < 0) ifirst = k;
          if (pul > 1 && lrun != ph(s)) werr++;
        end
        hrun++; lrun = 0;
      end else begin
        if (pinc && hrun != ph(s)) werr++;
        hrun = 0; lrun++;
      end
      pinc = ic[s];
      k++;
      @(negedge clk);
    end
    chk({tag, " latency"}, seen ? k : -1, x_lat);
    chk({tag, " pulses"}, pul, x_pul);
    chk({tag, " rst_lo_cycles"}, rlo, x_rlo);
    if (x_rlo > 0) chk({tag, " rst_lo_start"}, rfirst, ph(s));
    if (x_pul > 0) chk({tag, " first_inc"}, ifirst, x_ifirst);
    chk({tag, " invariants"}, viol, 0);
    chk({tag, " widths"}, werr, 0);
    chk({tag, " ena"}, en[s], e);
    chk({tag, " cur_addr"}, ca[s], a);
    chk({tag, " cur_valid"}, cv[s], 1);
    @(negedge clk);
    chk({tag, " done_pulse"}, dn[s], 0);
    mv[s] = 1'b1;
    ma[s] = a;
  endtask

  task automatic go(input int s, input int a, input bit e, input string tag);
    int lat, pul, rlo, ifirst;
    model(s, a, lat, pul, rlo, ifirst);
    run_req(s, a, e, 1'b0, 0, 1'b0, lat, pul, rlo, ifirst, tag);
  endtask

  initial begin
    int lat, pul, rlo, ifirst, cyc, rises;
    bit pinc;
    rv[0] = 1'b0; rv[1] = 1'b0; ra[0] = '0; ra[1] = '0; re[0] = 1'b0; re[1] = 1'b0;
    tbl[0] = '{a: 3,  e: 1'b1, lat: 19, pul: 3,  rlo: 2};
    tbl[1] = '{a: 0,  e: 1'b0, lat: 7,  pul: 0,  rlo: 2};
    tbl[2] = '{a: 1,  e: 1'b1, lat: 11, pul: 1,  rlo: 2};
    tbl[3] = '{a: 10, e: 1'b0, lat: 47, pul: 10, rlo: 2};
    repeat (2) @(negedge clk);

    // Directed vectors, each from a fresh reset so they are mode-independent.
    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_req(0, tbl[i].a, tbl[i].e, 1'b0, 0, 1'b0, tbl[i].lat, tbl[i].pul, tbl[i].rlo, 6, "tbl");
    end

    // Request held through busy with a different address.
    do_reset();
    run_req(0, 3, 1'b1, 1'b1, 6, 1'b0, 19, 3, 2, 6, "hold1");
    model(0, 6, lat, pul, rlo, ifirst);
    run_req(0, 6, 1'b0, 1'b0, 0, 1'b0, lat, pul, rlo, ifirst, "hold2");

    // Reset during the second inc-high phase.
    do_reset();
    rv[0] = 1'b1; ra[0] = 10'd5; re[0] = 1'b1;
    cyc = 0;
    while (!rr[0] && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    rv[0] = 1'b0;
    rises = 0; pinc = 1'b0; cyc = 0;
    while (rises < 2 && cyc < 200) begin
      if (ic[0] && !pinc) rises++;
      pinc = ic[0];
      if (rises < 2) begin @(negedge clk); cyc++; end
    end
    chk("midrst reached", rises, 2);
    #2 rst = 1'b1;
    #1;
    chk("midrst rst_n", rn[0], 0);
    chk("midrst inc", ic[0], 0);
    chk("midrst ena", en[0], 0);
    chk("midrst cur_valid", cv[0], 0);
    chk("midrst busy", bz[0], 0);
    @(negedge clk);
    rst = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0;
    @(negedge clk);
    go(0, 5, 1'b1, "post_rst");

    // Incremental selection behaviour (full sequence when the option is off).
    do_reset();
    go(0, 3, 1'b1, "seq_a3");
    go(0, 7, 1'b0, "seq_a7");
    go(0, 2, 1'b1, "seq_a2");
    go(0, 2, 1'b0, "seq_same");

    // Randomized requests, biased to sometimes repeat the current address.
    for (int i = 0; i < 16; i++) begin
      int a;
      bit e;
      a = ($urandom_range(0, 3) == 0 && mv[0]) ? ma[0] : int'($urandom_range(0, 12));
      e = 1'($urandom_range(0, 1));
      go(0, a, e, "rand");
    end

    // Full-range address, no counter wrap.
    go(1, 1023, 1'b1, "max");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
